// File: rtl/spike_vote_decoder_if.sv
// rtl/spike_vote_decoder_if.sv - run control, spike lines and class decision of the spike vote decoder
interface spike_vote_decoder_if;
  logic       enable;
  logic [2:0] spike_in;
  logic [1:0] network_output;
  logic       result_valid;

  modport master (
    output enable,
    output spike_in,
    input  network_output,
    input  result_valid
  );

  modport slave (
    input  enable,
    input  spike_in,
    output network_output,
    output result_valid
  );
endinterface

// File: rtl/spike_vote_decoder.sv
// rtl/spike_vote_decoder.sv - counts spike rising edges per output neuron over a fixed window and votes a class
module spike_vote_decoder #(
  parameter int WINDOW_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_vote_decoder_if.slave  bus
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DECIDE
  } state_t;

  state_t state;
  state_t next_state;

  logic [2:0]           sync_meta;
  logic [2:0]           sync_q;
  logic [2:0]           spike_dly;
  logic [2:0]           spike_edge;
  logic [CNT_WIDTH-1:0] cnt [3];
  logic [WIN_W-1:0]     win_cnt;
  logic [1:0]           decision;
  logic [1:0]           out_q;
  logic                 valid_q;
  logic                 count_en;
  logic                 decide_en;

  // Spike lines are asynchronous; the delay FF turns each synced high level into one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 3'b000;
      sync_q    <= 3'b000;
      spike_dly <= 3'b000;
    end else begin
      sync_meta <= bus.spike_in;
      sync_q    <= sync_meta;
      spike_dly <= sync_q;
    end
  end

  assign spike_edge = sync_q & ~spike_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    count_en   = 1'b0;
    decide_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          next_state = ST_COUNT;
        end
      end
      ST_COUNT: begin
        count_en = 1'b1;
        if (!bus.enable) begin
          next_state = ST_IDLE;
        end else if (win_cnt == WIN_LAST) begin
          next_state = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        decide_en  = 1'b1;
        next_state = bus.enable ? ST_COUNT : ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Edges seen during DECIDE seed the next window instead of being dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else if (count_en) begin
      win_cnt <= win_cnt + 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (spike_edge[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end else if (decide_en) begin
      win_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= CNT_WIDTH'(spike_edge[i]);
      end
    end else begin
      win_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end
  end

  // Only a strict maximum wins; ties (including all-zero and co-saturated counts) give 0.
  always_comb begin
    decision = 2'd0;
    if ((cnt[0] > cnt[1]) && (cnt[0] > cnt[2])) begin
      decision = 2'd1;
    end else if ((cnt[1] > cnt[0]) && (cnt[1] > cnt[2])) begin
      decision = 2'd2;
    end else if ((cnt[2] > cnt[0]) && (cnt[2] > cnt[1])) begin
      decision = 2'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= decide_en;
      if (decide_en) begin
        out_q <= decision;
      end
    end
  end

  assign bus.network_output = out_q;
  assign bus.result_valid   = valid_q;

endmodule
